sysbus_initiator: RTL and testbench
===================================

// Module: sysbus_initiator
// PURPOSE
//  Debug-module system bus access (SBA) engine: the initiating end of arilla_bus_if.
//  Turns debugger register operations (sbaddress/sbdata writes and reads) into single
//  read/write cycles on the system bus, used by the memories and peripherals there.
//  Byte/halfword/word accesses, lane alignment, autoincrement, read-on-addr/data,
//  RISC-V sberror/sbbusyerror reporting.
// PARAMETERS
//  DataWidth     32  bus data width; 4 byte lanes
//  AddressWidth  30  bus word-address width; byte address = {address, 2'b00}, 32 bits
//  MaxSize       2   largest legal sbaccess encoding (2 = 32-bit)
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  sbaccess        in   3   access size: 0=8b 1=16b 2=32b; >MaxSize illegal
//  sbautoincrement in   1   add (1<<sbaccess) to sbaddress after each access
//  sbreadonaddr    in   1   addr_wr starts a read
//  sbreadondata    in   1   data_rd starts a read
//  addr_wr         in   1   strobe: load sbaddress from wdata
//  data_wr         in   1   strobe: load sbdata from wdata, start write
//  data_rd         in   1   strobe: debugger consumed sbdata this cycle
//  wdata           in   32  value for addr_wr/data_wr
//  sberror_clr     in   1   clears sberror (w1c)
//  busyerror_clr   in   1   clears sbbusyerror (w1c)
//  sbaddress       out  32  current byte address
//  sbdata          out  32  read data / write data register
//  sbbusy          out  1   access in flight
//  sbbusyerror     out  1   sticky: command while busy
//  sberror         out  3   sticky: 0 none, 3 misaligned, 4 bad size
//  bus_interface   arilla_bus_if  initiator side: drives address, data, byte_enable,
//                  read, write; samples data_in; never drives intercept
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, bus read/write/byte_enable 0 immediately.
//  States: IDLE, WRITE, READ_REQ, READ_RESP.
//  Command accept (IDLE): addr_wr loads sbaddress; data_wr loads sbdata; registers still
//   load while sberror!=0 or sbbusyerror=1, but no access starts then.
//  Start checks: sbaccess>MaxSize -> sberror=4; sbaddress not aligned to size -> sberror=3;
//   either way no bus cycle, state stays IDLE.
//  Write: strobe cycle N -> WRITE at N+1: write=1 one cycle, address=sbaddress[31:2],
//   byte_enable = size mask << sbaddress[1:0], data = sbdata lane-replicated. sbbusy
//   high N+1 only; autoincrement applied at end of N+1.
//  Read: strobe N -> READ_REQ N+1 (read=1 one cycle) -> READ_RESP N+2: data_in sampled,
//   selected lane shifted down, zero-extended into sbdata; autoincrement at end of N+2.
//   sbbusy high N+1..N+2, low from N+3.
//  data_rd with sbreadondata: debugger sees old sbdata in cycle N; new read starts N+1.
//  addr_wr and data_wr same cycle: both load, write issued at the new address,
//   sbreadonaddr ignored.
//  Any strobe while sbbusy: sbbusyerror=1, strobe ignored entirely (no register update).
//  Autoincrement wraps modulo 2^32. No read/write ever asserted outside its state.
//  Error set and w1c clear same cycle: set wins.
//  Bus has fixed latency, no wait states; bus read data is valid only in READ_RESP.
// STRUCTURE
//  Package arilla_sba_pkg: state enum, sberror code constants, access-size enum,
//   size_mask() function.
//  Sub-module sba_lane_align: combinational byte_enable generation, write lane
//   replication, read lane extract/zero-extend.
// TESTING
//  1 sbaccess=2, addr_wr 0x1000, data_wr 0xDEADBEEF -> one write cycle, address 0x400,
//    byte_enable 4'b1111, data 0xDEADBEEF; sbbusy high 1 cycle.
//  2 memory word 0xAABBCCDD at 0x1000; sbaccess=0, readonaddr, addr_wr 0x1003 ->
//    read at 0x400, sbdata=0x000000AA, sbbusy high 2 cycles.
//  3 sbaccess=1, readonaddr, addr_wr 0x1001 -> sberror=3, no read/write pulse;
//    next data_wr blocked until sberror_clr.
//  4 sbaccess=2, autoincrement+readondata, sbaddress 0xFFFFFFFC, data_rd -> read
//    at 0x3FFFFFFF, sbaddress wraps to 0x00000000.
//  5 data_wr during READ_RESP -> sbbusyerror=1, sbdata holds read value; later strobes
//    start nothing until busyerror_clr.
//  6 rst_n low in READ_REQ -> read drops same cycle, sbbusy=0, sbdata=0, state IDLE.

Source files
------------

// File: rtl/arilla_sba_pkg.sv
// ============================================================================
// arilla_sba_pkg : shared types, error codes and helpers for the SBA engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package arilla_sba_pkg;

  localparam int unsigned SBA_DATA_WIDTH    = 32;
  localparam int unsigned SBA_ADDRESS_WIDTH = 30;
  localparam int unsigned SBA_MAX_SIZE      = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_REQ  = 2'd2,
    ST_READ_RESP = 2'd3
  } sba_state_t;

  typedef enum logic [2:0] {
    SIZE_8  = 3'd0,
    SIZE_16 = 3'd1,
    SIZE_32 = 3'd2
  } sba_size_t;

  localparam logic [2:0] SBERR_NONE       = 3'd0;
  localparam logic [2:0] SBERR_MISALIGNED = 3'd3;
  localparam logic [2:0] SBERR_BAD_SIZE   = 3'd4;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] offset, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return ~offset[0];
      default: return (offset == 2'd0);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/arilla_bus_if.sv
// ============================================================================
// arilla_bus_if : single-cycle system bus between SBA initiator and targets
// Revision: 1.0
// ============================================================================
`default_nettype none

interface arilla_bus_if;
  import arilla_sba_pkg::*;

  logic [SBA_ADDRESS_WIDTH-1:0] address;
  logic [SBA_DATA_WIDTH-1:0]    data;
  logic [SBA_DATA_WIDTH/8-1:0]  byte_enable;
  logic                         read;
  logic                         write;
  logic [SBA_DATA_WIDTH-1:0]    data_in;
  logic                         intercept;

  modport master (
    output address, data, byte_enable, read, write,
    input  data_in, intercept
  );

  modport slave (
    input  address, data, byte_enable, read, write,
    output data_in, intercept
  );

endinterface

`default_nettype wire

// File: rtl/sba_lane_align.sv
// ============================================================================
// sba_lane_align : byte-enable generation, write lane replication and
//                  read lane extraction with zero extension
// Revision: 1.0
// ============================================================================
`default_nettype none

module sba_lane_align
  import arilla_sba_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wr_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] lane_wdata,
  output logic [31:0] rd_data
);

  logic [31:0] w_shifted;

  assign byte_enable = size_mask(size[1:0]) << offset;
  assign w_shifted   = bus_rdata >> {offset, 3'b000};

  // Replication lets a target pick the addressed lane without any shifting.
  always_comb begin
    lane_wdata = wr_data;
    rd_data    = w_shifted;
    case (sba_size_t'(size))
      SIZE_8: begin
        lane_wdata = {4{wr_data[7:0]}};
        rd_data    = {24'd0, w_shifted[7:0]};
      end
      SIZE_16: begin
        lane_wdata = {2{wr_data[15:0]}};
        rd_data    = {16'd0, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sysbus_initiator.sv
// ============================================================================
// sysbus_initiator : debug-module system bus access engine turning sbaddress/
//                    sbdata operations into single bus read/write cycles
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysbus_initiator
  import arilla_sba_pkg::*;
#(
  parameter int unsigned MAX_SIZE = SBA_MAX_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   sbaccess,
  input  logic         sbautoincrement,
  input  logic         sbreadonaddr,
  input  logic         sbreadondata,
  input  logic         addr_wr,
  input  logic         data_wr,
  input  logic         data_rd,
  input  logic [31:0]  wdata,
  input  logic         sberror_clr,
  input  logic         busyerror_clr,
  output logic [31:0]  sbaddress,
  output logic [31:0]  sbdata,
  output logic         sbbusy,
  output logic         sbbusyerror,
  output logic [2:0]   sberror,
  arilla_bus_if.master bus_interface
);

  sba_state_t  r_state;
  sba_state_t  w_next_state;
  logic [31:0] r_sbaddress;
  logic [31:0] r_sbdata;
  logic        r_busyerror;
  logic [2:0]  r_sberror;

  logic        w_idle;
  logic        w_any_strobe;
  logic        w_blocked;
  logic        w_want_write;
  logic        w_want_read;
  logic [31:0] w_check_addr;
  logic        w_size_bad;
  logic        w_misaligned;
  logic        w_start_req;
  logic        w_start_ok;
  logic [31:0] w_inc_addr;
  logic [3:0]  w_byte_enable;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_read_data;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_any_strobe = addr_wr | data_wr | data_rd;
  assign w_blocked    = (r_sberror != SBERR_NONE) | r_busyerror;

  // A data write takes priority, so a combined addr/data strobe never reads.
  assign w_want_write = data_wr;
  assign w_want_read  = ~data_wr & ((addr_wr & sbreadonaddr) | (data_rd & sbreadondata));

  assign w_check_addr = addr_wr ? wdata : r_sbaddress;
  assign w_size_bad   = (sbaccess > 3'(MAX_SIZE));
  assign w_misaligned = ~is_aligned(w_check_addr[1:0], sbaccess[1:0]);
  assign w_start_req  = w_idle & ~w_blocked & (w_want_write | w_want_read);
  assign w_start_ok   = w_start_req & ~w_size_bad & ~w_misaligned;
  assign w_inc_addr   = r_sbaddress + (32'd1 << sbaccess[1:0]);

  sba_lane_align u_lane_align (
    .size        (sbaccess),
    .offset      (r_sbaddress[1:0]),
    .wr_data     (r_sbdata),
    .bus_rdata   (bus_interface.data_in),
    .byte_enable (w_byte_enable),
    .lane_wdata  (w_lane_wdata),
    .rd_data     (w_read_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next_state = w_want_write ? ST_WRITE : ST_READ_REQ;
        end
      end
      ST_WRITE:     w_next_state = ST_IDLE;
      ST_READ_REQ:  w_next_state = ST_READ_RESP;
      ST_READ_RESP: w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Bus strobes decode straight from state so reset removes them at once.
  always_comb begin
    sbbusy                    = 1'b0;
    bus_interface.read        = 1'b0;
    bus_interface.write       = 1'b0;
    bus_interface.byte_enable = 4'd0;
    case (r_state)
      ST_WRITE: begin
        sbbusy                    = 1'b1;
        bus_interface.write       = 1'b1;
        bus_interface.byte_enable = w_byte_enable;
      end
      ST_READ_REQ: begin
        sbbusy                    = 1'b1;
        bus_interface.read        = 1'b1;
        bus_interface.byte_enable = w_byte_enable;
      end
      ST_READ_RESP: begin
        sbbusy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbaddress <= 32'd0;
      r_sbdata    <= 32'd0;
    end else begin
      if (w_idle && addr_wr) begin
        r_sbaddress <= wdata;
      end
      if (w_idle && data_wr) begin
        r_sbdata <= wdata;
      end
      if (r_state == ST_WRITE && sbautoincrement) begin
        r_sbaddress <= w_inc_addr;
      end
      if (r_state == ST_READ_RESP) begin
        r_sbdata <= w_read_data;
        if (sbautoincrement) begin
          r_sbaddress <= w_inc_addr;
        end
      end
    end
  end

  // Error flags are sticky; a new error in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busyerror <= 1'b0;
      r_sberror   <= SBERR_NONE;
    end else begin
      if (!w_idle && w_any_strobe) begin
        r_busyerror <= 1'b1;
      end else if (busyerror_clr) begin
        r_busyerror <= 1'b0;
      end
      if (w_start_req && w_size_bad) begin
        r_sberror <= SBERR_BAD_SIZE;
      end else if (w_start_req && w_misaligned) begin
        r_sberror <= SBERR_MISALIGNED;
      end else if (sberror_clr) begin
        r_sberror <= SBERR_NONE;
      end
    end
  end

  assign sbaddress             = r_sbaddress;
  assign sbdata                = r_sbdata;
  assign sbbusyerror           = r_busyerror;
  assign sberror               = r_sberror;
  assign bus_interface.address = r_sbaddress[31:2];
  assign bus_interface.data    = w_lane_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sysbus_initiator.sv
// ============================================================================
// tb_sysbus_initiator : directed and randomized checks of sysbus_initiator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sysbus_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sbaccess = 3'd2;
  logic        sbautoincrement = 1'b0;
  logic        sbreadonaddr = 1'b0;
  logic        sbreadondata = 1'b0;
  logic        addr_wr = 1'b0;
  logic        data_wr = 1'b0;
  logic        data_rd = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        sberror_clr = 1'b0;
  logic        busyerror_clr = 1'b0;
  logic [31:0] sbaddress;
  logic [31:0] sbdata;
  logic        sbbusy;
  logic        sbbusyerror;
  logic [2:0]  sberror;

  arilla_bus_if bus_if ();

  sysbus_initiator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sbaccess        (sbaccess),
    .sbautoincrement (sbautoincrement),
    .sbreadonaddr    (sbreadonaddr),
    .sbreadondata    (sbreadondata),
    .addr_wr         (addr_wr),
    .data_wr         (data_wr),
    .data_rd         (data_rd),
    .wdata           (wdata),
    .sberror_clr     (sberror_clr),
    .busyerror_clr   (busyerror_clr),
    .sbaddress       (sbaddress),
    .sbdata          (sbdata),
    .sbbusy          (sbbusy),
    .sbbusyerror     (sbbusyerror),
    .sberror         (sberror),
    .bus_interface   (bus_if)
  );

  always #5 clk = ~clk;

  // Bus target: 8-word memory, one-cycle read latency, garbage outside responses.
  logic [31:0] mem [8];
  logic [31:0] ref_mem [8];

  assign bus_if.intercept = 1'b0;

  always @(posedge clk) begin
    if (bus_if.write) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_if.byte_enable[b]) mem[bus_if.address[2:0]][8*b +: 8] <= bus_if.data[8*b +: 8];
      end
    end
    if (bus_if.read) bus_if.data_in <= mem[bus_if.address[2:0]];
    else             bus_if.data_in <= $urandom;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state (debugger-visible registers)
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_data = 32'd0;
  logic [2:0]  m_err = 3'd0;
  bit          m_busyerr = 1'b0;
  int          exp_busy, exp_wr_n, exp_rd_n;
  logic [29:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;

  task automatic predict(input bit a_wr, input bit d_wr, input bit d_rd, input logic [31:0] wd);
    int unsigned nbytes, off, kind;
    logic [63:0] word;
    exp_busy = 0; exp_wr_n = 0; exp_rd_n = 0;
    kind = 0;
    if (a_wr) m_addr = wd;
    if (d_wr) m_data = wd;
    if (d_wr) kind = 1;
    else if ((a_wr && sbreadonaddr) || (d_rd && sbreadondata)) kind = 2;
    if (kind != 0 && m_err == 0 && !m_busyerr) begin
      nbytes = 1 << sbaccess;
      if (sbaccess > 2) m_err = 3'd4;
      else if (m_addr % nbytes != 0) m_err = 3'd3;
      else begin
        off = m_addr % 4;
        exp_addr = m_addr[31:2];
        if (kind == 1) begin
          exp_wr_n = 1; exp_busy = 1;
          exp_be = 4'(((1 << nbytes) - 1) << off);
          for (int b = 0; b < 4; b++) exp_wdata[8*b +: 8] = m_data[8*(b % nbytes) +: 8];
          for (int k = 0; k < int'(nbytes); k++) ref_mem[m_addr[4:2]][8*(off+k) +: 8] = m_data[8*k +: 8];
        end else begin
          exp_rd_n = 1; exp_busy = 2;
          word = {32'd0, ref_mem[m_addr[4:2]]};
          m_data = 32'((word >> (8*off)) & ((64'd1 << (8*nbytes)) - 64'd1));
        end
        if (sbautoincrement) m_addr = m_addr + nbytes;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".sbaddress"}, sbaddress, m_addr);
    check({tag, ".sbdata"}, sbdata, m_data);
    check({tag, ".sberror"}, 32'(sberror), 32'(m_err));
    check({tag, ".busyerror"}, 32'(sbbusyerror), 32'(m_busyerr));
  endtask

  task automatic run_cmd(input bit a_wr, input bit d_wr, input bit d_rd, input logic [31:0] wd,
                         input string tag);
    int          busy_n = 0, wr_n = 0, rd_n = 0, stray = 0;
    logic [29:0] wr_addr = '0, rd_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    @(negedge clk);
    addr_wr = a_wr; data_wr = d_wr; data_rd = d_rd; wdata = wd;
    #1;
    if (d_rd) check({tag, ".old_sbdata"}, sbdata, m_data);
    predict(a_wr, d_wr, d_rd, wd);
    @(negedge clk);
    addr_wr = 1'b0; data_wr = 1'b0; data_rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (sbbusy) busy_n++;
      if (bus_if.write) begin wr_n++; wr_addr = bus_if.address; wr_be = bus_if.byte_enable; wr_data = bus_if.data; end
      if (bus_if.read) begin rd_n++; rd_addr = bus_if.address; end
      if (!bus_if.write && !bus_if.read && bus_if.byte_enable != 4'd0) stray++;
    end
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, ".write_pulses"}, 32'(wr_n), 32'(exp_wr_n));
    check({tag, ".read_pulses"}, 32'(rd_n), 32'(exp_rd_n));
    check({tag, ".stray_be"}, 32'(stray), 32'd0);
    if (exp_wr_n == 1) begin
      check({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_addr));
      check({tag, ".wr_be"}, 32'(wr_be), 32'(exp_be));
      check({tag, ".wr_data"}, wr_data, exp_wdata);
    end
    if (exp_rd_n == 1) check({tag, ".rd_addr"}, 32'(rd_addr), 32'(exp_addr));
    check_regs(tag);
  endtask

  task automatic set_cfg(input logic [2:0] acc, input bit ainc, input bit roa, input bit rod);
    @(negedge clk);
    sbaccess = acc; sbautoincrement = ainc; sbreadonaddr = roa; sbreadondata = rod;
  endtask

  task automatic clear_errors(input string tag);
    @(negedge clk);
    sberror_clr = 1'b1; busyerror_clr = 1'b1;
    @(negedge clk);
    sberror_clr = 1'b0; busyerror_clr = 1'b0;
    m_err = 3'd0; m_busyerr = 1'b0;
    check({tag, ".sberror_cleared"}, 32'(sberror), 32'd0);
    check({tag, ".busyerror_cleared"}, 32'(sbbusyerror), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] addr;
    int          combo;
    int          r;

    for (int i = 0; i < 8; i++) begin
      w = $urandom; mem[i] = w; ref_mem[i] = w;
    end

    repeat (2) @(negedge clk);
    check("reset.sbaddress", sbaddress, 32'd0);
    check("reset.sbdata", sbdata, 32'd0);
    check("reset.sbbusy", 32'(sbbusy), 32'd0);
    check("reset.sberror", 32'(sberror), 32'd0);
    check("reset.busyerror", 32'(sbbusyerror), 32'd0);
    check("reset.bus_strobes", {28'd0, bus_if.byte_enable}
          | {30'd0, bus_if.read, bus_if.write}, 32'd0);
    rst_n = 1'b1;

    // Word write
    set_cfg(3'd2, 1'b0, 1'b0, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 32'h0000_1000, "t1_addr");
    run_cmd(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, "t1_write");
    check("t1.mem", mem[0], 32'hDEAD_BEEF);

    // Byte read from top lane
    run_cmd(1'b0, 1'b1, 1'b0, 32'hAABB_CCDD, "t2_fill");
    set_cfg(3'd0, 1'b0, 1'b1, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 32'h0000_1003, "t2_read");
    check("t2.sbdata_const", sbdata, 32'h0000_00AA);

    // Misaligned halfword, then blocked write until cleared
    set_cfg(3'd1, 1'b0, 1'b1, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 32'h0000_1001, "t3_misalign");
    check("t3.sberror_const", 32'(sberror), 32'd3);
    run_cmd(1'b0, 1'b1, 1'b0, 32'h0000_5A5A, "t3_blocked");
    clear_errors("t3");
    set_cfg(3'd1, 1'b0, 1'b0, 1'b0);
    run_cmd(1'b1, 1'b1, 1'b0, 32'h0000_1006, "t3_combined");

    // Autoincrement wrap at top of address space
    set_cfg(3'd2, 1'b0, 1'b0, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, "t4_addr");
    set_cfg(3'd2, 1'b1, 1'b0, 1'b1);
    run_cmd(1'b0, 1'b0, 1'b1, 32'h0, "t4_read");
    check("t4.wrap", sbaddress, 32'h0000_0000);

    // Strobe during READ_RESP
    set_cfg(3'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    addr_wr = 1'b1; wdata = 32'h0000_1000;
    predict(1'b1, 1'b0, 1'b0, 32'h0000_1000);
    @(negedge clk);
    addr_wr = 1'b0;
    @(negedge clk);
    data_wr = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    data_wr = 1'b0;
    m_busyerr = 1'b1;
    check_regs("t5_busy");
    run_cmd(1'b0, 1'b1, 1'b0, 32'h0BAD_0BAD, "t5_blocked");
    clear_errors("t5");

    // Reset during READ_REQ
    @(negedge clk);
    addr_wr = 1'b1; wdata = 32'h0000_1004;
    @(negedge clk);
    addr_wr = 1'b0;
    check("t6.read_before", 32'(bus_if.read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6.read_dropped", 32'(bus_if.read), 32'd0);
    check("t6.sbbusy", 32'(sbbusy), 32'd0);
    check("t6.sbdata", sbdata, 32'd0);
    check("t6.sbaddress", sbaddress, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = 32'd0; m_data = 32'd0; m_err = 3'd0; m_busyerr = 1'b0;
    run_cmd(1'b0, 1'b0, 1'b0, 32'd0, "t6_idle");

    // Randomized mix of sizes, modes and strobe combinations
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      set_cfg((r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           addr = 32'h0000_1000 + 32'($urandom_range(0, 31));
      combo = $urandom_range(1, 7);
      run_cmd(combo[0], combo[1], combo[2], combo[1] && !combo[0] ? $urandom : addr, "rnd");
      if ((m_err != 0 || m_busyerr) && $urandom_range(0, 1) == 1) clear_errors("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
